hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_pkg.sv | 32 +++
 rtl/hazard_control_unit_forward_select.sv | 35 +++
 rtl/hazard_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_pkg
// Shared pipeline definitions for the hazard control unit: FSM state encoding,
// operand forward-select codes, the default mul/div timeout, and a register
// match helper used by both the forwarding and the load-use logic.
// -----------------------------------------------------------------------------
package hazard_control_unit_pkg;

  // Control FSM states: normal issue, or waiting on the shared mul/div unit.
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hcu_state_t;

  // Operand source selects for the execute-stage ALU inputs.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register-file value
    FWD_WB  = 2'b01,  // ResultW
    FWD_MEM = 2'b10   // ALU_ResultM
  } fwd_sel_t;

  // Default maximum number of busy cycles before a mul/div abort.
  localparam int MD_TIMEOUT_DEFAULT = 64;

  // True when a producer register matches a consumer register. x0 is hardwired
  // to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] producer,
                                   input logic [4:0] consumer);
    return (producer != 5'd0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Picks the source of one execute-stage operand. The memory stage holds the
// younger result, so it takes priority over the writeback stage.
//
// Ports
//   rs             : source register number of the operand in E
//   rd_mem         : destination register of the instruction in M
//   rd_wb          : destination register of the instruction in W
//   reg_write_mem  : instruction in M writes the register file
//   reg_write_wb   : instruction in W writes the register file
//   sel            : FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module forward_select
  import hazard_control_unit_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_write_mem,
  input  logic       reg_write_wb,
  output logic [1:0] sel
);

  always_comb begin
    if (reg_write_mem && reg_hit(rd_mem, rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_wb && reg_hit(rd_wb, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard control: operand forwarding, load-use stalls, branch
// flushes, and stalling around the shared multi-cycle mul/div unit with a
// timeout abort. Also keeps stall and branch-flush performance counters.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   Rs1_D, Rs2_D             : source registers of the instruction in D
//   Rs1_E, Rs2_E, RD_E       : source/destination registers in E
//   RD_M, RD_W               : destination registers in M and W
//   RegWriteM, RegWriteW     : M / W instructions write the register file
//   ResultSrcE               : instruction in E is a load
//   PCSrcE                   : branch/jump taken in E
//   MdStartE, MdDoneE        : mul/div start and done pulses
//   ForwardA_E, ForwardB_E   : operand forward selects (combinational)
//   StallF/D/E, FlushD/E/M   : pipeline stage stall and flush controls
//   MdErr                    : sticky mul/div timeout flag
//   StallCnt, FlushCnt       : cycles with StallF, cycles with a branch flush
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic [4:0]  Rs1_E,
  input  logic [4:0]  Rs2_E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RD_M,
  input  logic [4:0]  RD_W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MdStartE,
  input  logic        MdDoneE,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdErr,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  // Busy counter wide enough to hold MD_TIMEOUT itself (its saturation value).
  localparam int               CNT_W     = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_MAX  = CNT_W'(MD_TIMEOUT);

  hcu_state_t       state;
  hcu_state_t       state_next;
  logic [CNT_W-1:0] busy_cnt;
  logic             load_use;
  logic             md_expired;
  logic             branch_flush;

  // ---------------------------------------------------------------------------
  // Forwarding: pure combinational, independent of reset and FSM state.
  // ---------------------------------------------------------------------------
  forward_select u_fwd_a (
    .rs            (Rs1_E),
    .rd_mem        (RD_M),
    .rd_wb         (RD_W),
    .reg_write_mem (RegWriteM),
    .reg_write_wb  (RegWriteW),
    .sel           (ForwardA_E)
  );

  forward_select u_fwd_b (
    .rs            (Rs2_E),
    .rd_mem        (RD_M),
    .rd_wb         (RD_W),
    .reg_write_mem (RegWriteM),
    .reg_write_wb  (RegWriteW),
    .sel           (ForwardB_E)
  );

  // ---------------------------------------------------------------------------
  // Hazard conditions
  // ---------------------------------------------------------------------------
  assign load_use = ResultSrcE && (reg_hit(RD_E, Rs1_D) || reg_hit(RD_E, Rs2_D));

  // busy_cnt is 0 in the first busy cycle, so BUSY_LAST marks the
  // MD_TIMEOUT-th busy cycle. A done in that same cycle wins.
  assign md_expired = (state == MD_BUSY) && !MdDoneE && (busy_cnt == BUSY_LAST);

  assign branch_flush = (state == RUN) && PCSrcE;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so every path assigns the signal and no latch is
    // inferred.
    state_next = state;
    case (state)
      RUN:     if (MdStartE && !PCSrcE)    state_next = MD_BUSY;
      MD_BUSY: if (MdDoneE || md_expired)  state_next = RUN;
      default:                             state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. All controls are held low while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          // A taken branch squashes the dependent instruction anyway, so the
          // flush overrides any load-use stall.
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MD_BUSY: begin
          // Front end stays frozen through the final busy cycle; E is
          // released on done, and squashed instead on a timeout abort.
          StallF = 1'b1;
          StallD = 1'b1;
          if (md_expired) begin
            FlushE = 1'b1;
          end else if (!MdDoneE) begin
            StallE = 1'b1;
            FlushM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Busy-cycle counter and sticky timeout flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
      MdErr    <= 1'b0;
    end else begin
      if (state == RUN) begin
        // Holding zero in RUN clears the count on entry to MD_BUSY.
        busy_cnt <= '0;
      end else if (busy_cnt != BUSY_MAX) begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end
      if (md_expired) begin
        MdErr <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCnt <= 32'd0;
      FlushCnt <= 32'd0;
    end else begin
      if (StallF)       StallCnt <= StallCnt + 32'd1;
      if (branch_flush) FlushCnt <= FlushCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed bench for hazard_control_unit. Inputs change 1 time unit after the
// rising edge; registered outputs are sampled on the falling edge.
// Control vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM}.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MdStartE, MdDoneE;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdErr;
  logic [31:0] StallCnt, FlushCnt;
  logic [5:0]  ctl;

  int checks = 0;
  int fails  = 0;

  localparam logic [5:0] CTL_NONE   = 6'b000000;
  localparam logic [5:0] CTL_LOAD   = 6'b110010;
  localparam logic [5:0] CTL_BRANCH = 6'b000110;
  localparam logic [5:0] CTL_BUSY   = 6'b111001;
  localparam logic [5:0] CTL_DONE   = 6'b110000;
  localparam logic [5:0] CTL_ABORT  = 6'b110010;

  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .Rs1_E      (Rs1_E),
    .Rs2_E      (Rs2_E),
    .RD_E       (RD_E),
    .RD_M       (RD_M),
    .RD_W       (RD_W),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MdStartE   (MdStartE),
    .MdDoneE    (MdDoneE),
    .ForwardA_E (ForwardA_E),
    .ForwardB_E (ForwardB_E),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .MdErr      (MdErr),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  task automatic idle();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MdStartE = 0; MdDoneE = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    rst = 1'b0;
    // Hazards present during reset must not raise controls or counters.
    PCSrcE = 1; ResultSrcE = 1; RD_E = 3; Rs2_D = 3;
    @(negedge clk);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_NONE); end
    checks++; if (StallCnt !== 32'd0) begin fails++; $display("FAIL reset_stallcnt got %0d want 0", StallCnt); end
    checks++; if (FlushCnt !== 32'd0) begin fails++; $display("FAIL reset_flushcnt got %0d want 0", FlushCnt); end
    checks++; if (MdErr !== 1'b0) begin fails++; $display("FAIL reset_mderr got %b want 0", MdErr); end
    idle();
    rst = 1'b1;
    advance();
  endtask

  task automatic test_forwarding();
    RD_M = 5; RD_W = 5; Rs1_E = 5; RegWriteM = 1; RegWriteW = 1; #1;
    checks++; if (ForwardA_E !== 2'b10) begin fails++; $display("FAIL fwd_mem_priority got %b want 10", ForwardA_E); end
    RegWriteM = 0; #1;
    checks++; if (ForwardA_E !== 2'b01) begin fails++; $display("FAIL fwd_wb got %b want 01", ForwardA_E); end
    RegWriteM = 1; RD_M = 0; RD_W = 0; Rs1_E = 0; #1;
    checks++; if (ForwardA_E !== 2'b00) begin fails++; $display("FAIL fwd_x0 got %b want 00", ForwardA_E); end
    RD_M = 9; RD_W = 7; Rs1_E = 9; Rs2_E = 7; #1;
    checks++; if (ForwardA_E !== 2'b10) begin fails++; $display("FAIL fwd_a_mem got %b want 10", ForwardA_E); end
    checks++; if (ForwardB_E !== 2'b01) begin fails++; $display("FAIL fwd_b_wb got %b want 01", ForwardB_E); end
    RegWriteW = 0; #1;
    checks++; if (ForwardB_E !== 2'b00) begin fails++; $display("FAIL fwd_b_nowrite got %b want 00", ForwardB_E); end
    RD_M = 7; RegWriteM = 1; #1;
    checks++; if (ForwardB_E !== 2'b10) begin fails++; $display("FAIL fwd_b_mem got %b want 10", ForwardB_E); end
    idle();
    advance();
  endtask

  task automatic test_load_use();
    logic [31:0] s0, f0;
    s0 = StallCnt; f0 = FlushCnt;
    ResultSrcE = 1; RD_E = 3; Rs2_D = 3; Rs1_D = 1;
    @(negedge clk);
    checks++; if (ctl !== CTL_LOAD) begin fails++; $display("FAIL load_use_ctl got %b want %b", ctl, CTL_LOAD); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL load_use_one_cycle got %b want %b", ctl, CTL_NONE); end
    checks++; if (StallCnt !== s0 + 32'd1) begin fails++; $display("FAIL load_use_stallcnt got %0d want %0d", StallCnt, s0 + 32'd1); end
    checks++; if (FlushCnt !== f0) begin fails++; $display("FAIL load_use_flushcnt got %0d want %0d", FlushCnt, f0); end
    advance();
    // Load into x0 never stalls.
    ResultSrcE = 1; RD_E = 0; Rs1_D = 0; Rs2_D = 0;
    @(negedge clk);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL load_use_x0 got %b want %b", ctl, CTL_NONE); end
    advance();
    // Match on Rs1_D.
    ResultSrcE = 1; RD_E = 12; Rs1_D = 12; Rs2_D = 4;
    @(negedge clk);
    checks++; if (ctl !== CTL_LOAD) begin fails++; $display("FAIL load_use_rs1 got %b want %b", ctl, CTL_LOAD); end
    advance();
    // Same registers but not a load.
    ResultSrcE = 0;
    @(negedge clk);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL load_use_not_load got %b want %b", ctl, CTL_NONE); end
    idle();
    advance();
  endtask

  task automatic test_flush_over_stall();
    logic [31:0] s0, f0;
    s0 = StallCnt; f0 = FlushCnt;
    ResultSrcE = 1; RD_E = 3; Rs2_D = 3; PCSrcE = 1;
    @(negedge clk);
    checks++; if (ctl !== CTL_BRANCH) begin fails++; $display("FAIL flush_over_stall_ctl got %b want %b", ctl, CTL_BRANCH); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (FlushCnt !== f0 + 32'd1) begin fails++; $display("FAIL flush_cnt got %0d want %0d", FlushCnt, f0 + 32'd1); end
    checks++; if (StallCnt !== s0) begin fails++; $display("FAIL flush_stallcnt got %0d want %0d", StallCnt, s0); end
    advance();
  endtask

  task automatic test_md_op();
    logic [31:0] s0, f0;
    int se, sf;
    s0 = StallCnt; f0 = FlushCnt; se = 0; sf = 0;
    MdStartE = 1;
    @(negedge clk);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL md_start_cycle got %b want %b", ctl, CTL_NONE); end
    advance();
    for (int i = 1; i <= 6; i++) begin
      idle();
      if (i == 2) begin PCSrcE = 1; MdStartE = 1; ResultSrcE = 1; RD_E = 3; Rs1_D = 3; end
      if (i == 6) MdDoneE = 1;
      @(negedge clk);
      se += int'(StallE);
      sf += int'(StallF);
      checks++;
      if (ctl !== ((i == 6) ? CTL_DONE : CTL_BUSY)) begin
        fails++;
        $display("FAIL md_busy_cycle%0d got %b want %b", i, ctl, (i == 6) ? CTL_DONE : CTL_BUSY);
      end
      advance();
    end
    idle();
    @(negedge clk);
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL md_back_to_run got %b want %b", ctl, CTL_NONE); end
    checks++; if (se != 5) begin fails++; $display("FAIL md_stalle_cycles got %0d want 5", se); end
    checks++; if (sf != 6) begin fails++; $display("FAIL md_stallf_cycles got %0d want 6", sf); end
    checks++; if (StallCnt !== s0 + 32'd6) begin fails++; $display("FAIL md_stallcnt got %0d want %0d", StallCnt, s0 + 32'd6); end
    checks++; if (FlushCnt !== f0) begin fails++; $display("FAIL md_branch_ignored got %0d want %0d", FlushCnt, f0); end
    advance();
  endtask

  task automatic test_timeout();
    logic [31:0] s0;
    int pulses;
    s0 = StallCnt; pulses = 0;
    MdStartE = 1;
    advance();
    idle();
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      pulses += int'(FlushE);
      checks++;
      if (ctl !== ((i == 64) ? CTL_ABORT : CTL_BUSY)) begin
        fails++;
        $display("FAIL timeout_cycle%0d got %b want %b", i, ctl, (i == 64) ? CTL_ABORT : CTL_BUSY);
      end
      checks++; if (MdErr !== 1'b0) begin fails++; $display("FAIL timeout_early_mderr cycle%0d got %b want 0", i, MdErr); end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(FlushE);
      checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL timeout_run%0d got %b want %b", i, ctl, CTL_NONE); end
      checks++; if (MdErr !== 1'b1) begin fails++; $display("FAIL timeout_mderr%0d got %b want 1", i, MdErr); end
      advance();
    end
    checks++; if (pulses != 1) begin fails++; $display("FAIL timeout_flushe_pulses got %0d want 1", pulses); end
    checks++; if (StallCnt !== s0 + 32'd64) begin fails++; $display("FAIL timeout_stallcnt got %0d want %0d", StallCnt, s0 + 32'd64); end
  endtask

  task automatic test_reset_mid_busy();
    MdStartE = 1;
    advance();
    idle();
    for (int i = 1; i < 10; i++) advance();
    checks++; if (ctl !== CTL_BUSY) begin fails++; $display("FAIL rst_busy_pre got %b want %b", ctl, CTL_BUSY); end
    RD_M = 5; Rs1_E = 5; RegWriteM = 1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL rst_busy_ctl got %b want %b", ctl, CTL_NONE); end
    checks++; if (StallCnt !== 32'd0) begin fails++; $display("FAIL rst_busy_stallcnt got %0d want 0", StallCnt); end
    checks++; if (FlushCnt !== 32'd0) begin fails++; $display("FAIL rst_busy_flushcnt got %0d want 0", FlushCnt); end
    checks++; if (MdErr !== 1'b0) begin fails++; $display("FAIL rst_busy_mderr got %b want 0", MdErr); end
    checks++; if (ForwardA_E !== 2'b10) begin fails++; $display("FAIL rst_fwd_live got %b want 10", ForwardA_E); end
    @(negedge clk);
    idle();
    rst = 1'b1;
    advance();
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL rst_busy_run got %b want %b", ctl, CTL_NONE); end
    checks++; if (StallCnt !== 32'd0) begin fails++; $display("FAIL rst_busy_post_stallcnt got %0d want 0", StallCnt); end
  endtask

  task automatic test_done_vs_timeout();
    MdStartE = 1;
    advance();
    idle();
    for (int i = 1; i < 64; i++) advance();
    MdDoneE = 1;
    @(negedge clk);
    checks++; if (ctl !== CTL_DONE) begin fails++; $display("FAIL done_wins_ctl got %b want %b", ctl, CTL_DONE); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (MdErr !== 1'b0) begin fails++; $display("FAIL done_wins_mderr got %b want 0", MdErr); end
    checks++; if (ctl !== CTL_NONE) begin fails++; $display("FAIL done_wins_run got %b want %b", ctl, CTL_NONE); end
    advance();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_over_stall();
    test_md_op();
    test_timeout();
    test_reset_mid_busy();
    test_done_vs_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
